// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the cache-line burst adaptor: line/beat sizes,
// address offset width and the adaptor FSM state encoding.
package cache_types_pkg;

   localparam int BEATS       = 4;
   localparam int BURST_W     = 64;
   localparam int LINE_W      = 256;
   localparam int OFFSET_BITS = 5;

   typedef logic [LINE_W-1:0]  line_t;
   typedef logic [BURST_W-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      RESP
   } adaptor_state_t;

endpackage

// File: rtl/line_shift_buffer.sv
// Line-wide register with whole-line load and beat-indexed write/select.
// Assembles read beats into a line and slices a latched write line into beats.
module line_shift_buffer #(
   parameter int BEATS   = 4,
   parameter int BURST_W = 64,
   parameter int LINE_W  = 256,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               load_i,
   input  logic [LINE_W-1:0]  line_i,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   idx_i,
   input  logic [BURST_W-1:0] beat_i,
   output logic [LINE_W-1:0]  line_o,
   output logic [BURST_W-1:0] beat_o
);
   import cache_types_pkg::*;

   logic [LINE_W-1:0] line_q;
   logic [LINE_W-1:0] line_d;

   // Whole-line load takes priority over a single-beat write.
   always_comb begin
      line_d = line_q;
      if (load_i) begin
         line_d = line_i;
      end else if (we_i) begin
         line_d[idx_i*BURST_W +: BURST_W] = beat_i;
      end
   end

   always_ff @(posedge clk) begin
      line_q <= line_d;
   end

   assign line_o = line_q;
   assign beat_o = line_q[idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Optional CACHELINE_ADAPTOR_PERF_EN adds saturating read/write completion counters.
module cacheline_burst_adaptor #(
   parameter int BEATS   = cache_types_pkg::BEATS,
   parameter int BURST_W = cache_types_pkg::BURST_W,
   parameter int LINE_W  = cache_types_pkg::LINE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               line_read,
   input  logic               line_write,
   input  logic [31:0]        line_address,
   input  logic [LINE_W-1:0]  line_wdata,
   output logic [LINE_W-1:0]  line_rdata,
   output logic               line_resp,
   output logic               mem_read,
   output logic               mem_write,
   output logic [31:0]        mem_address,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               mem_resp
`ifdef CACHELINE_ADAPTOR_PERF_EN
   ,
   output logic [31:0]        perf_reads,
   output logic [31:0]        perf_writes
`endif
);
   import cache_types_pkg::*;

   localparam int CNT_W = $clog2(BEATS);

   if (LINE_W != BEATS * BURST_W) begin : g_bad_geometry
      $error("LINE_W must equal BEATS*BURST_W");
   end

   adaptor_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              is_wr_q, is_wr_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;

   logic               buf_load;
   logic               buf_we;
   logic [LINE_W-1:0]  buf_line;
   logic [BURST_W-1:0] buf_beat;
   logic               last_beat;

   line_shift_buffer #(
      .BEATS  (BEATS),
      .BURST_W(BURST_W),
      .LINE_W (LINE_W),
      .IDX_W  (CNT_W)
   ) u_buf (
      .clk   (clk),
      .load_i(buf_load),
      .line_i(line_wdata),
      .we_i  (buf_we),
      .idx_i (cnt_q),
      .beat_i(burst_i),
      .line_o(buf_line),
      .beat_o(buf_beat)
   );

   assign last_beat = mem_resp && (cnt_q == CNT_W'(BEATS - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      is_wr_d   = is_wr_q;
      rdata_d   = rdata_q;
      buf_load  = 1'b0;
      buf_we    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      line_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (line_write) begin
               addr_d   = line_address & ~((32'd1 << OFFSET_BITS) - 32'd1);
               cnt_d    = '0;
               is_wr_d  = 1'b1;
               buf_load = 1'b1;
               state_d  = WR_BURST;
            end else if (line_read) begin
               addr_d  = line_address & ~((32'd1 << OFFSET_BITS) - 32'd1);
               cnt_d   = '0;
               is_wr_d = 1'b0;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               buf_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end
            // The final beat bypasses the buffer so the line is published with the resp.
            if (last_beat) begin
               rdata_d = buf_line;
               rdata_d[(BEATS-1)*BURST_W +: BURST_W] = burst_i;
               state_d = RESP;
            end
         end
         WR_BURST: begin
            mem_write = 1'b1;
            if (mem_resp) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (last_beat) begin
               state_d = RESP;
            end
         end
         RESP: begin
            line_resp = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_address = addr_q;
   assign line_rdata  = rdata_q;
   assign burst_o     = (state_q == WR_BURST) ? buf_beat : '0;

`ifdef CACHELINE_ADAPTOR_PERF_EN
   logic [31:0] perf_reads_q, perf_reads_d;
   logic [31:0] perf_writes_q, perf_writes_d;

   always_comb begin
      perf_reads_d  = perf_reads_q;
      perf_writes_d = perf_writes_q;
      if (state_q == RESP) begin
         if (is_wr_q && (perf_writes_q != 32'hFFFF_FFFF)) begin
            perf_writes_d = perf_writes_q + 32'd1;
         end
         if (!is_wr_q && (perf_reads_q != 32'hFFFF_FFFF)) begin
            perf_reads_d = perf_reads_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_reads_q  <= '0;
         perf_writes_q <= '0;
      end else begin
         perf_reads_q  <= perf_reads_d;
         perf_writes_q <= perf_writes_d;
      end
   end

   assign perf_reads  = perf_reads_q;
   assign perf_writes = perf_writes_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: transaction-level model compared every cycle,
// plus literal checks on latency, assembled data and write beat order.
module tb_cacheline_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         line_read = 1'b0;
   logic         line_write = 1'b0;
   logic [31:0]  line_address = '0;
   logic [255:0] line_wdata = '0;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [63:0]  burst_o;
   logic [63:0]  burst_i = '0;
   logic         mem_resp = 1'b0;
`ifdef CACHELINE_ADAPTOR_PERF_EN
   logic [31:0]  perf_reads;
   logic [31:0]  perf_writes;
`endif

   cacheline_burst_adaptor dut (
      .clk         (clk),
      .rst         (rst),
      .line_read   (line_read),
      .line_write  (line_write),
      .line_address(line_address),
      .line_wdata  (line_wdata),
      .line_rdata  (line_rdata),
      .line_resp   (line_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .burst_o     (burst_o),
      .burst_i     (burst_i),
      .mem_resp    (mem_resp)
`ifdef CACHELINE_ADAPTOR_PERF_EN
      ,
      .perf_reads  (perf_reads),
      .perf_writes (perf_writes)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 reading, 2 writing, 3 responding.
   int           m_phase = 0;
   int           m_beat = 0;
   bit           m_on = 0;
   bit           m_isrd = 0;
   logic [31:0]  m_addr = '0;
   logic [255:0] m_wline = '0;
   logic [255:0] m_rbuf = '0;
   logic [255:0] m_rdata = '0;
   logic [31:0]  m_pr = '0;
   logic [31:0]  m_pw = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_beat = 0; m_addr = '0; m_rdata = '0; m_pr = '0; m_pw = '0; m_on = 1;
      end else if (m_on) begin
         case (m_phase)
            0: if (line_write) begin
                  m_phase = 2; m_isrd = 0; m_beat = 0;
                  m_addr = {line_address[31:5], 5'b0}; m_wline = line_wdata;
               end else if (line_read) begin
                  m_phase = 1; m_isrd = 1; m_beat = 0;
                  m_addr = {line_address[31:5], 5'b0};
               end
            1: if (mem_resp) begin
                  m_rbuf[m_beat*64 +: 64] = burst_i;
                  m_beat++;
                  if (m_beat == 4) begin m_phase = 3; m_rdata = m_rbuf; end
               end
            2: if (mem_resp) begin
                  m_beat++;
                  if (m_beat == 4) m_phase = 3;
               end
            default: begin
               if (m_isrd) m_pr = m_pr + 1; else m_pw = m_pw + 1;
               m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("mem_read", mem_read, m_phase == 1);
         chk("mem_write", mem_write, m_phase == 2);
         chk("line_resp", line_resp, m_phase == 3);
         chk("mem_address", mem_address, m_addr);
         chk("burst_o", burst_o, (m_phase == 2) ? m_wline[(m_beat%4)*64 +: 64] : 64'd0);
         chk("line_rdata", line_rdata, m_rdata);
`ifdef CACHELINE_ADAPTOR_PERF_EN
         chk("perf_reads", perf_reads, m_pr);
         chk("perf_writes", perf_writes, m_pw);
`endif
      end
   end

   logic [63:0] rbeats [4];
   logic [63:0] wcap [4];
   logic [31:0] cap_addr;
   bit          seen_rd, seen_wr;

   task automatic xact(input bit wr, input bit rd, input logic [31:0] a, input int gap,
                       input bit keep_rd, output int lat);
      int  b, g;
      bit  done;
      b = 0; g = 0; done = 0; lat = 0; seen_rd = 0; seen_wr = 0;
      line_write = wr; line_read = rd; line_address = a;
      for (int n = 1; n <= 300 && !done; n++) begin
         @(posedge clk); #1;
         mem_resp = 1'b0;
         if (mem_read) seen_rd = 1;
         if (mem_write) seen_wr = 1;
         if (line_resp) begin
            done = 1; lat = n + 1;
            line_write = 1'b0; line_read = keep_rd;
         end else if ((mem_read || mem_write) && b < 4) begin
            if (g >= gap) begin
               mem_resp = 1'b1; burst_i = rbeats[b];
               wcap[b] = burst_o; cap_addr = mem_address;
               b++; g = 0;
            end else begin
               g++;
            end
         end
      end
      chk("xact_done", done, 1'b1);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] WR_LINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

   initial begin
      int lat;
      cyc(3);
      rst = 1'b0;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_line_resp", line_resp, 1'b0);
      chk("rst_rdata", line_rdata, 256'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_burst_o", burst_o, 64'd0);

      // Back-to-back read
      rbeats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      xact(0, 1, 32'h0000_1234, 0, 0, lat);
      chk("rd_latency", lat, 6);
      chk("rd_addr", cap_addr, 32'h0000_1220);
      chk("rd_data", line_rdata, RD_LINE);
      cyc(2);

      // Read with two idle cycles before every beat
      xact(0, 1, 32'h0000_1234, 2, 0, lat);
      chk("rd_gap_latency", lat, 14);
      chk("rd_gap_data", line_rdata, RD_LINE);
      cyc(2);

      // Write burst
      line_wdata = WR_LINE;
      xact(1, 0, 32'h8000_007F, 0, 0, lat);
      chk("wr_beat0", wcap[0], 64'hAAAA_AAAA_AAAA_AAAA);
      chk("wr_beat1", wcap[1], 64'hBBBB_BBBB_BBBB_BBBB);
      chk("wr_beat2", wcap[2], 64'hCCCC_CCCC_CCCC_CCCC);
      chk("wr_beat3", wcap[3], 64'hDDDD_DDDD_DDDD_DDDD);
      chk("wr_addr", cap_addr, 32'h8000_0060);
      chk("wr_keeps_rdata", line_rdata, RD_LINE);
      cyc(2);

      // Simultaneous requests: write first, held read next
      rbeats = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
      line_wdata = ~WR_LINE;
      xact(1, 1, 32'h0000_4000, 0, 1, lat);
      chk("simul_wr_seen", seen_wr, 1'b1);
      chk("simul_rd_seen", seen_rd, 1'b0);
      xact(0, 1, 32'h0000_4000, 0, 0, lat);
      chk("held_rd_data", line_rdata, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                       64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
      cyc(2);

      // Reset after two read beats
      line_read = 1'b1; line_address = 32'h0000_ABCD;
      cyc(1);
      mem_resp = 1'b1; burst_i = 64'h9999_9999_9999_9999;
      cyc(1);
      burst_i = 64'h9898_9898_9898_9898;
      cyc(1);
      mem_resp = 1'b0; rst = 1'b1; line_read = 1'b0;
      cyc(1);
      chk("midrst_mem_read", mem_read, 1'b0);
      chk("midrst_line_resp", line_resp, 1'b0);
      chk("midrst_rdata", line_rdata, 256'd0);
      rst = 1'b0;
      mem_resp = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      cyc(1);
      mem_resp = 1'b0;
      cyc(1);
      rbeats = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                 64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
      xact(0, 1, 32'h0000_ABCD, 1, 0, lat);
      chk("fresh_rd_data", line_rdata, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                        64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
      cyc(2);

`ifdef CACHELINE_ADAPTOR_PERF_EN
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin xact(0, 1, 32'h100 * i, 0, 0, lat); cyc(1); end
      for (int i = 0; i < 2; i++) begin xact(1, 0, 32'h200 * i, 0, 0, lat); cyc(1); end
      cyc(1);
      chk("perf_reads_lit", perf_reads, 32'd3);
      chk("perf_writes_lit", perf_writes, 32'd2);
`endif

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Responder for the 256-bit line interface that the cache arbiter drives toward memory.
- Accepts one line read or write and performs it as a 4-beat, 64-bit burst on the physical memory port.
- Reads: assembles beats into a line. Writes: splits the line into beats.
- Sits between the arbiter's L2-side port and the memory model/DRAM controller.

Parameters:
- BEATS, 4, beats per line.
- BURST_W, 64, bits per beat.
- LINE_W, 256, line width; must equal BEATS*BURST_W (elaboration-time check).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- line_read  in  1  line read request; held until line_resp.
- line_write  in  1  line write request; held until line_resp.
- line_address  in  32  byte address of line.
- line_wdata  in  LINE_W  write line.
- line_rdata  out  LINE_W  read line, valid when line_resp=1.
- line_resp  out  1  one-cycle completion pulse.
- mem_read  out  1  burst read request.
- mem_write  out  1  burst write request.
- mem_address  out  32  line-aligned burst address.
- burst_o  out  BURST_W  current write beat.
- burst_i  in  BURST_W  read beat, valid when mem_resp=1.
- mem_resp  in  1  per-beat acknowledge.

Behaviour:
- Clock and reset: clk and rst; rst is synchronous, active-high.
- Reset values: all outputs 0, including line_rdata, line_resp, mem_read, mem_write, mem_address and burst_o. State is IDLE; beat counter is 0.
- FSM states: IDLE, RD_BURST, WR_BURST, RESP.
- IDLE:
  - line_write=1 → latch line_address with the low 5 bits forced to 0, latch line_wdata, counter=0, go to WR_BURST.
  - Otherwise line_read=1 → latch the aligned address, counter=0, go to RD_BURST.
  - Write wins if both requests are high.
- RD_BURST:
  - mem_read=1 and mem_address=latched address, held continuously until the last beat.
  - On each cycle with mem_resp=1, burst_i is stored into line buffer slice [counter*64 +: 64] and the counter increments.
  - Beats need not be consecutive; cycles with mem_resp=0 store nothing.
  - On the 4th mem_resp, mem_read drops in the next cycle and the FSM goes to RESP.
- WR_BURST:
  - mem_write=1; burst_o = latched wdata slice [counter*64 +: 64].
  - The counter advances on each mem_resp; burst_o updates in the cycle after each acknowledged beat.
  - On the 4th mem_resp, go to RESP.
- RESP:
  - line_resp=1 for exactly one cycle; line_rdata holds the assembled line and stays stable until the next read completes.
  - Always go to IDLE next.
  - The requester deasserts its request in the cycle after line_resp. A request still high in IDLE after that starts a new transaction.
- Request inputs are sampled only in IDLE. Changes to line_address or line_wdata mid-transaction are ignored, because they were latched.
- Latency:
  - Read: line_resp asserts 1 cycle after the 4th mem_resp.
  - Minimum total with back-to-back beats: 1 (accept) + 4 + 1 = 6 cycles from request to line_resp.
- Counter is 2 bits wide and wraps to 0 after beat 3; the wrap coincides with the exit from the burst state.
- Reset mid-burst: return to IDLE at once; mem_read/mem_write are 0 in the next cycle and partial data is discarded. Beats arriving while in IDLE are ignored.
- mem_resp outside a burst state is ignored.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_PERF_EN.
- When defined:
  - Adds outputs perf_reads [31:0] and perf_writes [31:0], each incremented in the RESP cycle for its transaction type.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_types_pkg:
  - Constants LINE_W, BURST_W, BEATS, OFFSET_BITS=5.
  - Typedefs line_t (logic[255:0]) and beat_t (logic[63:0]).
  - Enum adaptor_state_t.
- Sub-module: line_shift_buffer.
  - A 256-bit register with beat-indexed load and select, used for both read assembly and write slicing.
  - The top module holds only the FSM and counter.

Test Plan:
- Read with back-to-back beats:
  - Stimulus: line_read=1, addr=0x0000_1234; burst_i = 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive mem_resp.
  - Response: mem_address=0x0000_1220; line_resp in cycle 6; line_rdata = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Read with gaps:
  - Stimulus: mem_resp with 2 idle cycles between beats.
  - Response: mem_read stays high throughout; line_resp exactly 1 cycle after the 4th beat; data identical to the back-to-back case.
- Write:
  - Stimulus: line_write=1, wdata = 256'h…DDDD_CCCC_BBBB_AAAA pattern (beat 0 = 64'hAAAA…).
  - Response: burst_o sequence AAAA, BBBB, CCCC, DDDD; one line_resp; mem_write=0 in RESP.
- Simultaneous requests:
  - Stimulus: line_read=1 and line_write=1 in IDLE.
  - Response: mem_write=1, mem_read=0; after resp, line_write drops and the held read is serviced next.
- Reset mid-burst:
  - Stimulus: rst after 2 read beats.
  - Response: next cycle mem_read=0 and line_resp=0. A fresh read afterwards returns only its own 4 beats.
- Perf counters (with CACHELINE_ADAPTOR_PERF_EN):
  - Stimulus: 3 reads and 2 writes.
  - Response: perf_reads=3, perf_writes=2.
